// File: rtl/calculate_statistics_deadlock_report_ctrl.sv
// Deadlock report controller for calculate_statistics HLS monitors.
// Filters stalls, latches sticky trips, drains them round-robin as reports.
module calculate_statistics_deadlock_report_ctrl #(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2,
  parameter int THRESH  = 1024,
  parameter int CNT_W   = 16,
  parameter int TS_W    = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [NUM_MON-1:0] mon_block,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IDX_W-1:0]   rpt_idx,
  output logic [TS_W-1:0]    rpt_ts,
  output logic [NUM_MON-1:0] pending,
  output logic               ovf,
  output logic               irq
);

  localparam logic [CNT_W-1:0] THR    = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESH - 1);

  typedef enum logic {
    S_IDLE,
    S_VALID
  } state_e;

  state_e state_q, state_d;

  logic [TS_W-1:0]                ts_q;
  logic [NUM_MON-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_MON-1:0][TS_W-1:0]   trip_ts_q;
  logic [NUM_MON-1:0]             trip;
  logic [NUM_MON-1:0]             pend_q, pend_d;
  logic [NUM_MON-1:0]             cons;
  logic                           ovf_q, ovf_d;
  logic                           irq_q;
  logic [IDX_W-1:0]               ptr_q;
  logic [IDX_W-1:0]               rpt_idx_q;
  logic [TS_W-1:0]                rpt_ts_q;
  logic [IDX_W-1:0]               rr_sel;
  logic [IDX_W-1:0]               cand;
  logic                           rr_found;
  logic                           hs;
  logic                           load;

  // Free-running timestamp, frozen while disabled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q <= '0;
    end else if (enable) begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  // Persistence counters; trip fires once on the THRESH-th blocked cycle
  always_comb begin
    cnt_d = '0;
    trip  = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      if (!clear && enable && mon_block[i]) begin
        trip[i] = (cnt_q[i] == THR_M1);
        if (cnt_q[i] == THR) begin
          cnt_d[i] = cnt_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Counter state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Capture trip timestamp; a repeat trip overwrites with the newer one
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trip_ts_q <= '0;
    end else begin
      for (int i = 0; i < NUM_MON; i++) begin
        if (trip[i]) begin
          trip_ts_q[i] <= ts_q;
        end
      end
    end
  end

  // Sticky pending/ovf update; a trip on the consumed index re-arms it
  always_comb begin
    cons   = hs ? (NUM_MON'(1) << rpt_idx_q) : '0;
    pend_d = (pend_q & ~cons) | trip;
    ovf_d  = ovf_q | (|(trip & pend_q & ~cons));
    if (clear) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end
  end

  // Pending, overflow and interrupt registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      irq_q  <= (|pend_q) | ovf_q;
    end
  end

  // Round-robin pick: first pending bit above the last grant, wrapping
  always_comb begin
    rr_sel   = ptr_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_MON; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_MON);
      if (!rr_found && pend_q[cand]) begin
        rr_sel   = cand;
        rr_found = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (|pend_q) state_d = S_VALID;
        S_VALID: if (rpt_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    rpt_valid = (state_q == S_VALID);
    hs        = rpt_valid && rpt_ready;
    load      = (state_q == S_IDLE) && (|pend_q) && !clear;
  end

  // Report payload and grant pointer, held while the report is offered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q     <= IDX_W'(NUM_MON - 1);
      rpt_idx_q <= '0;
      rpt_ts_q  <= '0;
    end else if (load) begin
      ptr_q     <= rr_sel;
      rpt_idx_q <= rr_sel;
      rpt_ts_q  <= trip_ts_q[rr_sel];
    end
  end

  assign rpt_idx = rpt_idx_q;
  assign rpt_ts  = rpt_ts_q;
  assign pending = pend_q;
  assign ovf     = ovf_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_calculate_statistics_deadlock_report_ctrl.sv
// Directed testbench for the deadlock report controller.
// NUM_MON=4, THRESH=8; expected values computed by hand.
module tb_calculate_statistics_deadlock_report_ctrl;

  localparam int NM = 4;
  localparam int IW = 2;
  localparam int TH = 8;
  localparam int CW = 16;
  localparam int TW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [NM-1:0] mon_block = '0;
  logic          rpt_ready = 1'b0;
  logic          rpt_valid;
  logic [IW-1:0] rpt_idx;
  logic [TW-1:0] rpt_ts;
  logic [NM-1:0] pending;
  logic          ovf;
  logic          irq;

  int errors = 0;
  int checks = 0;
  logic [TW-1:0] ts_m = '0;
  logic [TW-1:0] tsa;
  logic [TW-1:0] tsb;
  logic [NM-1:0] pe;

  calculate_statistics_deadlock_report_ctrl #(
    .NUM_MON(NM), .IDX_W(IW), .THRESH(TH), .CNT_W(CW), .TS_W(TW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .mon_block(mon_block), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_idx(rpt_idx), .rpt_ts(rpt_ts), .pending(pending),
    .ovf(ovf), .irq(irq)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    if (enable) ts_m = ts_m + 1;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #4;
    reset = 1'b0;
    ts_m = '0;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    apply_reset();
    checks++;
    if ({rpt_valid, pending, ovf, irq} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got v=%b p=%b o=%b i=%b want 0",
               rpt_valid, pending, ovf, irq);
    end
    checks++;
    if (rpt_idx !== 2'd0 || rpt_ts !== 32'd0) begin
      errors++;
      $display("FAIL reset_payload got idx=%0d ts=%0d want 0/0", rpt_idx, rpt_ts);
    end
  endtask

  task automatic test_single();
    repeat (10) tick();
    mon_block = 4'b0100;
    repeat (7) tick();
    checks++;
    if (pending !== 4'b0000) begin
      errors++;
      $display("FAIL single_early got p=%b want 0000", pending);
    end
    tick();
    checks++;
    if (pending !== 4'b0100 || irq !== 1'b0 || rpt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_c18 got p=%b irq=%b v=%b want 0100/0/0",
               pending, irq, rpt_valid);
    end
    tick();
    checks++;
    if (irq !== 1'b1 || rpt_valid !== 1'b1 || rpt_idx !== 2'd2 || rpt_ts !== 32'd17) begin
      errors++;
      $display("FAIL single_rpt got irq=%b v=%b idx=%0d ts=%0d want 1/1/2/17",
               irq, rpt_valid, rpt_idx, rpt_ts);
    end
    rpt_ready = 1'b1;
    tick();
    checks++;
    if (rpt_valid !== 1'b0 || pending !== 4'b0000 || irq !== 1'b1) begin
      errors++;
      $display("FAIL single_hs got v=%b p=%b irq=%b want 0/0000/1",
               rpt_valid, pending, irq);
    end
    rpt_ready = 1'b0;
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL single_irq_drop got irq=%b want 0", irq);
    end
    mon_block = '0;
    tick();
  endtask

  task automatic test_glitch();
    for (int ph = 0; ph < 4; ph++) begin
      int n;
      n = (ph == 1) ? 1 : ((ph == 3) ? 3 : 7);
      mon_block = (ph == 0 || ph == 2) ? 4'b0010 : 4'b0000;
      for (int c = 0; c < n; c++) begin
        tick();
        checks++;
        if (pending !== 4'b0000 || rpt_valid !== 1'b0) begin
          errors++;
          $display("FAIL glitch ph=%0d c=%0d got p=%b v=%b want 0000/0",
                   ph, c, pending, rpt_valid);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    mon_block = 4'b1111;
    rpt_ready = 1'b0;
    repeat (8) tick();
    checks++;
    if (pending !== 4'b1111 || rpt_valid !== 1'b0) begin
      errors++;
      $display("FAIL rr_trip got p=%b v=%b want 1111/0", pending, rpt_valid);
    end
    tick();
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (rpt_valid !== 1'b1 || rpt_idx !== 2'd0 || rpt_ts !== 32'd7) begin
        errors++;
        $display("FAIL rr_hold c=%0d got v=%b idx=%0d ts=%0d want 1/0/7",
                 c, rpt_valid, rpt_idx, rpt_ts);
      end
      tick();
    end
    rpt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rpt_valid !== 1'b1 || rpt_idx !== IW'(k) || rpt_ts !== 32'd7) begin
        errors++;
        $display("FAIL rr_order k=%0d got v=%b idx=%0d ts=%0d want 1/%0d/7",
                 k, rpt_valid, rpt_idx, rpt_ts, k);
      end
      tick();
      pe = 4'b1111;
      pe = pe << (k + 1);
      checks++;
      if (rpt_valid !== 1'b0 || pending !== pe || ovf !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap k=%0d got v=%b p=%b ovf=%b want 0/%b/0",
                 k, rpt_valid, pending, ovf, pe);
      end
      tick();
    end
    checks++;
    if (rpt_valid !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL rr_done got v=%b ovf=%b want 0/0", rpt_valid, ovf);
    end
    rpt_ready = 1'b0;
    mon_block = '0;
    tick();
  endtask

  task automatic test_overflow();
    mon_block = 4'b0001;
    repeat (8) tick();
    tick();
    checks++;
    if (rpt_valid !== 1'b1 || rpt_idx !== 2'd0) begin
      errors++;
      $display("FAIL ovf_first got v=%b idx=%0d want 1/0", rpt_valid, rpt_idx);
    end
    mon_block = 4'b1001;
    repeat (7) tick();
    tsa = ts_m;
    tick();
    checks++;
    if (pending !== 4'b1001 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_trip1 got p=%b ovf=%b want 1001/0", pending, ovf);
    end
    mon_block = 4'b0001;
    tick();
    mon_block = 4'b1001;
    repeat (7) tick();
    tsb = ts_m;
    tick();
    checks++;
    if (ovf !== 1'b1 || pending !== 4'b1001 || rpt_valid !== 1'b1 || rpt_idx !== 2'd0) begin
      errors++;
      $display("FAIL ovf_trip2 got ovf=%b p=%b v=%b idx=%0d want 1/1001/1/0",
               ovf, pending, rpt_valid, rpt_idx);
    end
    rpt_ready = 1'b1;
    tick();
    checks++;
    if (pending !== 4'b1000 || rpt_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain0 got p=%b v=%b want 1000/0", pending, rpt_valid);
    end
    tick();
    checks++;
    if (rpt_valid !== 1'b1 || rpt_idx !== 2'd3 || rpt_ts !== tsb || tsb !== tsa + 32'd9) begin
      errors++;
      $display("FAIL ovf_rpt got v=%b idx=%0d ts=%0d want 1/3/%0d",
               rpt_valid, rpt_idx, rpt_ts, tsb);
    end
    tick();
    checks++;
    if (pending !== 4'b0000 || ovf !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got p=%b ovf=%b irq=%b want 0000/1/1",
               pending, ovf, irq);
    end
    rpt_ready = 1'b0;
    mon_block = '0;
    tick();
  endtask

  task automatic test_clear();
    mon_block = 4'b0101;
    repeat (8) tick();
    tick();
    checks++;
    if (rpt_valid !== 1'b1 || rpt_idx !== 2'd0 || pending !== 4'b0101 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL clr_pre got v=%b idx=%0d p=%b ovf=%b want 1/0/0101/1",
               rpt_valid, rpt_idx, pending, ovf);
    end
    clear = 1'b1;
    mon_block = '0;
    tick();
    clear = 1'b0;
    checks++;
    if (rpt_valid !== 1'b0 || pending !== 4'b0000 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_next got v=%b p=%b ovf=%b want 0/0000/0",
               rpt_valid, pending, ovf);
    end
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL clr_irq got irq=%b want 0", irq);
    end
    rpt_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (rpt_valid !== 1'b0 || pending !== 4'b0000) begin
        errors++;
        $display("FAIL clr_quiet c=%0d got v=%b p=%b want 0/0000",
                 c, rpt_valid, pending);
      end
    end
    rpt_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    mon_block = 4'b0010;
    repeat (8) tick();
    tick();
    checks++;
    if (rpt_valid !== 1'b1 || rpt_idx !== 2'd1) begin
      errors++;
      $display("FAIL ar_pre got v=%b idx=%0d want 1/1", rpt_valid, rpt_idx);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({rpt_valid, pending, ovf, irq} !== 7'b0) begin
      errors++;
      $display("FAIL ar_async got v=%b p=%b o=%b i=%b want 0",
               rpt_valid, pending, ovf, irq);
    end
    #2;
    reset = 1'b0;
    ts_m = '0;
    mon_block = 4'b1001;
    repeat (8) tick();
    tick();
    checks++;
    if (rpt_valid !== 1'b1 || rpt_idx !== 2'd0 || rpt_ts !== 32'd7) begin
      errors++;
      $display("FAIL ar_first got v=%b idx=%0d ts=%0d want 1/0/7",
               rpt_valid, rpt_idx, rpt_ts);
    end
    rpt_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (rpt_valid !== 1'b1 || rpt_idx !== 2'd3) begin
      errors++;
      $display("FAIL ar_second got v=%b idx=%0d want 1/3", rpt_valid, rpt_idx);
    end
    rpt_ready = 1'b0;
    mon_block = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_round_robin();
    test_overflow();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
